motor_ramp: RTL

MOTOR_RAMP -- requirements
Module: motor_ramp

---
 rtl/motor_pkg.sv | 24 ++
 rtl/ramp_chan.sv | 58 +++++
 rtl/motor_ramp.sv | 108 ++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared types and limits for the two-wheel speed ramp.
// Speeds are 11-bit two's complement, held to a symmetric range.
package motor_pkg;

    localparam int unsigned MTR_W  = 11;
    localparam int unsigned DIFF_W = 12;

    typedef logic signed [MTR_W-1:0] motor_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        ESTOP = 2'd2
    } motor_state_t;

    localparam motor_cmd_t MTR_MAX = 11'sd1023;
    localparam motor_cmd_t MTR_MIN = -11'sd1023;

    // -1024 has no positive mirror; fold it onto the legal minimum.
    function automatic motor_cmd_t clamp_tgt(input motor_cmd_t t);
        return (t < MTR_MIN) ? MTR_MIN : t;
    endfunction

endpackage

// File: rtl/ramp_chan.sv
// One wheel: target/output registers and the bounded step toward the target.
module ramp_chan
    import motor_pkg::*;
#(
    parameter int unsigned STEP = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_ld,
    input  logic       i_step_en,
    input  motor_cmd_t i_tgt,
    output motor_cmd_t o_out,
    output logic       o_done_c,
    output logic       o_differs_c
);

    localparam logic signed [DIFF_W-1:0] STEP_S = DIFF_W'(STEP);

    motor_cmd_t               r_tgt;
    motor_cmd_t               r_out;
    motor_cmd_t               w_tgt_cl;
    motor_cmd_t               w_stepped;
    logic signed [DIFF_W-1:0] w_diff;

    assign w_tgt_cl = clamp_tgt(i_tgt);

    // Sign-extended difference cannot wrap, so the step never overshoots.
    assign w_diff = {r_tgt[MTR_W-1], r_tgt} - {r_out[MTR_W-1], r_out};

    always_comb begin
        w_stepped = r_tgt;
        if (w_diff > STEP_S) begin
            w_stepped = r_out + MTR_W'(STEP);
        end else if (w_diff < -STEP_S) begin
            w_stepped = r_out - MTR_W'(STEP);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_tgt <= '0;
            r_out <= '0;
        end else begin
            if (i_step_en) begin
                r_out <= w_stepped;
            end
            if (i_ld) begin
                r_tgt <= w_tgt_cl;
            end
        end
    end

    assign o_out       = r_out;
    assign o_done_c    = (r_out == r_tgt);
    assign o_differs_c = (w_tgt_cl != r_out);

endmodule

// File: rtl/motor_ramp.sv
// Dual-channel speed ramp: prescaled tick, IDLE/RAMP/ESTOP control,
// one ramp_chan per wheel.
module motor_ramp
    import motor_pkg::*;
#(
    parameter int unsigned STEP     = 8,
    parameter int unsigned PRESCALE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    input  logic [10:0] lft_tgt,
    input  logic [10:0] rht_tgt,
    input  logic        estop,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        at_tgt
);

    localparam int unsigned CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    motor_state_t     r_state;
    motor_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_at_tgt;
    logic             w_tick;
    logic             w_accept;
    logic             w_step_en;
    logic             w_done_l;
    logic             w_done_r;
    logic             w_diff_l;
    logic             w_diff_r;
    logic             w_new_move;
    motor_cmd_t       w_lft;
    motor_cmd_t       w_rht;

    assign cmd_rdy    = !estop && (r_state != ESTOP);
    assign w_accept   = cmd_vld && cmd_rdy;
    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_step_en  = w_tick && (r_state == RAMP);
    assign w_new_move = w_accept && (w_diff_l || w_diff_r);

    // Free-running prescaler; command acceptance never disturbs its phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_at_tgt <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_at_tgt <= (w_state_nxt != RAMP);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (estop) begin
            w_state_nxt = ESTOP;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = w_new_move ? RAMP : IDLE;
                RAMP:    w_state_nxt = (w_done_l && w_done_r && !w_new_move) ? IDLE : RAMP;
                ESTOP:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    ramp_chan #(.STEP(STEP)) u_lft (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr       (estop),
        .i_ld        (w_accept),
        .i_step_en   (w_step_en),
        .i_tgt       (lft_tgt),
        .o_out       (w_lft),
        .o_done_c    (w_done_l),
        .o_differs_c (w_diff_l)
    );

    ramp_chan #(.STEP(STEP)) u_rht (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clr       (estop),
        .i_ld        (w_accept),
        .i_step_en   (w_step_en),
        .i_tgt       (rht_tgt),
        .o_out       (w_rht),
        .o_done_c    (w_done_r),
        .o_differs_c (w_diff_r)
    );

    assign lft    = w_lft;
    assign rht    = w_rht;
    assign at_tgt = r_at_tgt;

endmodule
